// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch (I) and load/store (D) ports.
// D has priority; a streak counter forces an I grant after MAX_D_STREAK D grants while I waits.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int LATENCY      = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int CW = $clog2(LATENCY + 1);
  localparam int SW = $clog2(MAX_D_STREAK + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);
  localparam logic [SW-1:0] SMAX = SW'(MAX_D_STREAK);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [SW-1:0] streak;
  logic owner_d, idle, rd_gnt, done;
  // Gating with rst keeps grants and memory strobes low while reset is held.
  always_comb begin
    idle      = rst && state == IDLE;
    d_gnt     = idle && d_req && !(i_req && streak == SMAX);
    i_gnt     = idle && i_req && !d_gnt;
    rd_gnt    = i_gnt || (d_gnt && !d_we);
    done      = state == WAIT && cnt == '0;
    mem_en    = i_gnt || d_gnt;
    mem_we    = d_gnt && d_we;
    mem_addr  = d_gnt ? d_addr : i_gnt ? i_addr : '0;
    mem_wdata = d_gnt ? d_wdata : '0;
    state_nx  = rd_gnt ? WAIT : done ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt      <= '0;
      streak   <= '0;
      owner_d  <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_rdata  <= '0;
    end else begin
      i_rvalid <= done && !owner_d;
      d_rvalid <= done && owner_d;
      if (done && !owner_d) i_rdata <= mem_rdata;
      if (done && owner_d) d_rdata <= mem_rdata;
      if (rd_gnt) begin
        cnt     <= CNT_INIT;
        owner_d <= d_gnt;
      end else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
      if (i_gnt) streak <= '0;
      else if (d_gnt) streak <= !i_req ? '0 : streak == SMAX ? streak : streak + 1'b1;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench with a latency memory model and per-port read-data scoreboards.
module tb_mem_arbiter;
  localparam int LAT = 2;
  localparam int MAXS = 4;
  logic        clk = 1'b0, rst = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
  int checks = 0, errors = 0;
  logic [31:0] iq[$], dq[$];
  logic [31:0] wmem [256];
  bit          wv [256];
  logic [31:0] pipe [LAT];

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT), .MAX_D_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    return wv[a[9:2]] ? wmem[a[9:2]] : a == 32'h40 ? 32'h00A00093 : {a[15:0], ~a[15:0]};
  endfunction

  // Memory model: writes land at the grant edge, read data appears LAT cycles after mem_en.
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      wmem[mem_addr[9:2]] <= mem_wdata;
      wv[mem_addr[9:2]]   <= 1'b1;
    end
    pipe[0] <= (mem_en && !mem_we) ? rd(mem_addr) : 32'h0;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_rdata = pipe[LAT-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge rst) begin
    iq.delete();
    dq.delete();
  end

  always @(negedge clk) begin
    if (i_rvalid) begin
      if (iq.size() == 0) chk("i_rvalid_spurious", 1, 0);
      else chk("i_rdata_sb", i_rdata, iq.pop_front());
    end
    if (d_rvalid) begin
      if (dq.size() == 0) chk("d_rvalid_spurious", 1, 0);
      else chk("d_rdata_sb", d_rdata, dq.pop_front());
    end
  end

  task automatic step(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                      input logic [31:0] da, input logic [31:0] dwd);
    @(negedge clk);
    i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    #1;
    chk("gnt_exclusive", i_gnt && d_gnt, 0);
    chk("gnt_needs_req", (i_gnt && !i_req) || (d_gnt && !d_req), 0);
    if (i_gnt) iq.push_back(rd(i_addr));
    if (d_gnt && !d_we) dq.push_back(rd(d_addr));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    i_req = 1; d_req = 1; i_addr = 32'h40; d_addr = 32'h8;
    #1;
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rvalid", {i_rvalid, d_rvalid}, 0);
    chk("rst_rdata", {i_rdata, d_rdata}, 0);
    @(negedge clk);
    rst = 1; i_req = 0; d_req = 0;
    // reset in the middle of a fetch
    step(1, 32'h10, 0, 0, 0, 0);
    chk("mr_gnt", i_gnt, 1);
    @(negedge clk);
    i_req = 0; rst = 0;
    #1;
    chk("mr_mem_en", mem_en, 0);
    chk("mr_outs", {i_gnt, d_gnt, i_rvalid, d_rvalid, mem_we}, 0);
    @(negedge clk);
    rst = 1;
    repeat (4) idle();
    step(1, 32'h20, 0, 0, 0, 0);
    chk("mr_regrant", i_gnt, 1);
    repeat (3) idle();
    // single fetch, with a store waiting behind it
    step(1, 32'h40, 0, 0, 0, 0);
    chk("sf_gnt", i_gnt, 1);
    chk("sf_en", mem_en, 1);
    chk("sf_addr", mem_addr, 32'h40);
    chk("sf_we", mem_we, 0);
    step(0, 0, 1, 1, 32'h8, 32'hDEADBEEF);
    chk("sf_wait1_d_gnt", d_gnt, 0);
    chk("sf_wait1_en", mem_en, 0);
    chk("sf_wait1_rv", i_rvalid, 0);
    step(0, 0, 1, 1, 32'h8, 32'hDEADBEEF);
    chk("sf_wait2_d_gnt", d_gnt, 0);
    chk("sf_wait2_rv", i_rvalid, 0);
    step(0, 0, 1, 1, 32'h8, 32'hDEADBEEF);
    chk("sf_rvalid", i_rvalid, 1);
    chk("sf_rdata", i_rdata, 32'h00A00093);
    chk("st_gnt", d_gnt, 1);
    chk("st_we", mem_we, 1);
    chk("st_addr", mem_addr, 32'h8);
    chk("st_wdata", mem_wdata, 32'hDEADBEEF);
    // store followed at once by a load of the same word
    step(0, 0, 1, 0, 32'h8, 0);
    chk("ld_gnt", d_gnt, 1);
    chk("ld_we", mem_we, 0);
    chk("sf_rvalid_pulse", i_rvalid, 0);
    chk("st_no_rvalid", d_rvalid, 0);
    chk("sf_rdata_hold", i_rdata, 32'h00A00093);
    idle();
    chk("ld_wait_rv", d_rvalid, 0);
    idle();
    chk("ld_wait2_rv", d_rvalid, 0);
    idle();
    chk("ld_rvalid", d_rvalid, 1);
    chk("ld_rdata", d_rdata, 32'hDEADBEEF);
    idle();
    chk("ld_rvalid_pulse", d_rvalid, 0);
    // contention: both read at once, D first
    step(1, 32'h44, 1, 0, 32'h0C, 0);
    chk("ct_d_gnt", d_gnt, 1);
    chk("ct_i_wait", i_gnt, 0);
    chk("ct_addr", mem_addr, 32'h0C);
    step(1, 32'h44, 0, 0, 0, 0);
    chk("ct_i_wait1", i_gnt, 0);
    step(1, 32'h44, 0, 0, 0, 0);
    chk("ct_i_wait2", i_gnt, 0);
    step(1, 32'h44, 0, 0, 0, 0);
    chk("ct_d_rvalid", d_rvalid, 1);
    chk("ct_i_gnt", i_gnt, 1);
    chk("ct_i_addr", mem_addr, 32'h44);
    idle();
    idle();
    idle();
    chk("ct_i_rvalid", i_rvalid, 1);
    // starvation guard: streaming D writes with I pending
    for (int k = 0; k < 5; k++) begin
      step(1, 32'h48, 1, 1, 32'h80 + 4 * k, 32'h100 + k);
      chk("sv_d_gnt", d_gnt, k < MAXS);
      chk("sv_i_gnt", i_gnt, k == MAXS);
    end
    step(0, 0, 1, 1, 32'h90, 32'h55);
    chk("sv_wait1", d_gnt, 0);
    step(0, 0, 1, 1, 32'h90, 32'h55);
    chk("sv_wait2", d_gnt, 0);
    step(0, 0, 1, 1, 32'h90, 32'h55);
    chk("sv_d_regnt", d_gnt, 1);
    chk("sv_i_rvalid", i_rvalid, 1);
    // back-to-back writes without I, then I joins the traffic
    for (int k = 0; k < 8; k++) begin
      step(0, 0, 1, 1, 32'hA0 + 4 * k, 32'h200 + k);
      chk("bb_d_gnt", d_gnt, 1);
    end
    for (int k = 0; k < 5; k++) begin
      step(1, 32'h84, 1, 1, 32'hC0 + 4 * k, 32'h300 + k);
      chk("bb_d_gnt2", d_gnt, k < MAXS);
      chk("bb_i_gnt", i_gnt, k == MAXS);
    end
    repeat (4) idle();
    chk("sb_i_empty", iq.size(), 0);
    chk("sb_d_empty", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
